// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// Readback verification is enabled with `define CCFF_LOADER_READBACK_EN.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first step of the CRC-16 shift register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16 accumulator with synchronous clear to the init value.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = crc16_step(crc_q, data_in);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words MSB-first onto a configuration chain and paces it via cfg_clk_en.
// Optional readback CRC check of the chain contents: `define CCFF_LOADER_READBACK_EN.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              cfg_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WCNT_W = $clog2(WORDS + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORDS_C  = WCNT_W'(WORDS);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic load_shift, last_shift, accept, take_start;

    // The buffer shifts left, so the bit being driven is always its MSB.
    assign load_shift = (state_q == ST_LOAD) && buf_vld_q;
    assign last_shift = load_shift && (cnt_q == LAST_CNT);
    assign bs_ready   = (state_q == ST_LOAD) && (wcnt_q != WORDS_C)
                        && (!buf_vld_q || (idx_q == LAST_IDX));
    assign accept     = bs_valid && bs_ready;
    assign take_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        // NOTE: every output gets a default first, otherwise the unassigned paths infer latches.
        cfg_clk_en = 1'b0;
        ccff_head  = head_q;
        if (load_shift) begin
            cfg_clk_en = 1'b1;
            ccff_head  = buf_q[WORD_W-1];
        end
`ifdef CCFF_LOADER_READBACK_EN
        if (state_q == ST_VERIFY) begin
            cfg_clk_en = 1'b1;
            ccff_head  = ccff_tail;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        cnt_d     = cnt_q;
        head_d    = ccff_head;

        if (load_shift) begin
            buf_d = buf_q << 1;
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (idx_q == LAST_IDX) buf_vld_d = 1'b0;
        end
        if (accept) begin
            buf_d     = bs_data;
            buf_vld_d = 1'b1;
            idx_d     = '0;
            wcnt_d    = wcnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (take_start) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    wcnt_d    = '0;
                    idx_d     = '0;
                    buf_vld_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (last_shift) begin
                    // Leftover low bits of the final word are dropped here.
                    buf_vld_d = 1'b0;
                    cnt_d     = '0;
`ifdef CCFF_LOADER_READBACK_EN
                    state_d   = ST_VERIFY;
`else
                    state_d   = ST_DONE;
`endif
                end
            end
`ifdef CCFF_LOADER_READBACK_EN
            ST_VERIFY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            buf_vld_d = 1'b0;
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            cnt_q     <= '0;
            head_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] crc_load, crc_rb;

    ccff_crc16_serial u_crc_load (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (take_start),
        .enable   (load_shift),
        .data_in  (buf_q[WORD_W-1]),
        .crc_out  (crc_load)
    );

    ccff_crc16_serial u_crc_rb (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (take_start),
        .enable   (state_q == ST_VERIFY),
        .data_in  (ccff_tail),
        .crc_out  (crc_rb)
    );

    // Both CRCs are frozen in DONE, so the comparison holds until the next start.
    assign error = done_q && (crc_load != crc_rb);
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign error       = 1'b0;
`endif

endmodule
